// File: rtl/c7bexu_lsu_pkg.sv
// Shared types and encodings for the c7bexu load/store sequencer.
package c7bexu_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLs1,
        StLs2,
        StLs3
    } lsu_state_t;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;

    localparam int unsigned LSU_TIMEOUT = 255;

endpackage

// File: rtl/c7bexu_lsu_ext.sv
// Load data byte-lane extraction with sign or zero extension.
module c7bexu_lsu_ext
    import c7bexu_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            LSU_SZ_B: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            LSU_SZ_H: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default:  data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/c7bexu_lsu_ctl.sv
// LSU sequencer: alignment check (LS1), bus handshake with timeout (LS2),
// single completion/exception pulse (LS3).
module c7bexu_lsu_ctl
    import c7bexu_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_vld_e,
    input  logic        lsu_wr_e,
    input  logic        lsu_unsigned_e,
    input  logic [1:0]  lsu_size_e,
    input  logic [31:0] lsu_addr_e,
    input  logic [31:0] lsu_wdata_e,
    input  logic        ecl_flush,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic        bus_ecc,
    input  logic [31:0] bus_rdata,
    output logic        lsu_busy,
    output logic        lsu_except_ale_ls1,
    output logic        lsu_except_buserr_ls3,
    output logic        lsu_except_ecc_ls3,
    output logic        lsu_data_valid_ls3,
    output logic        lsu_wr_fin_ls3,
    output logic [31:0] lsu_rdata_ls3
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t     state_q, state_d;
    logic           wr_q, wr_d, uns_q, uns_d;
    logic [1:0]     size_q, size_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           to_q, to_d, kill_q, kill_d, err_q, err_d, ecc_q, ecc_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           misaligned, ls2, ls3_live, fail;
    logic [3:0]     be;
    logic [31:0]    wdata_rep, ext_data;

    c7bexu_lsu_ext u_ext (
        .rdata_i    (bus_rdata),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        case (size_q)
            LSU_SZ_B: misaligned = 1'b0;
            LSU_SZ_H: misaligned = addr_q[0];
            LSU_SZ_W: misaligned = |addr_q[1:0];
            default:  misaligned = 1'b1;
        endcase
        case (size_q)
            LSU_SZ_B: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            LSU_SZ_H: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        uns_d   = uns_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        kill_d  = kill_q;
        err_d   = err_q;
        ecc_d   = ecc_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                kill_d = 1'b0;
                if (lsu_vld_e) begin
                    wr_d    = lsu_wr_e;
                    uns_d   = lsu_unsigned_e;
                    size_d  = lsu_size_e;
                    addr_d  = lsu_addr_e;
                    wdata_d = lsu_wdata_e;
                    state_d = StLs1;
                end
            end
            StLs1: begin
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = (ecl_flush || misaligned) ? StIdle : StLs2;
            end
            StLs2: begin
                if (ecl_flush) kill_d = 1'b1;
                // An ack on the final wait cycle takes precedence over the timeout.
                if (bus_ack) begin
                    err_d   = bus_err;
                    ecc_d   = bus_ecc;
                    rdata_d = ext_data;
                    state_d = StLs3;
                end else if (cnt_q == LastCnt) begin
                    to_d    = 1'b1;
                    state_d = StLs3;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLs3:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            ecc_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
            ecc_q   <= ecc_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ls2      = (state_q == StLs2);
        ls3_live = (state_q == StLs3) && !kill_q && !ecl_flush;
        fail     = err_q || to_q;

        bus_req   = ls2;
        bus_wr    = ls2 & wr_q;
        bus_addr  = ls2 ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be    = ls2 ? be : 4'd0;
        bus_wdata = ls2 ? wdata_rep : 32'd0;

        lsu_busy              = (state_q != StIdle);
        lsu_except_ale_ls1    = (state_q == StLs1) && misaligned && !ecl_flush;
        lsu_except_buserr_ls3 = ls3_live && fail;
        lsu_except_ecc_ls3    = ls3_live && !fail && !wr_q && ecc_q;
        lsu_data_valid_ls3    = ls3_live && !fail && !wr_q && !ecc_q;
        lsu_wr_fin_ls3        = ls3_live && !fail && wr_q;
        lsu_rdata_ls3         = rdata_q;
    end

endmodule

// File: tb/tb_c7bexu_lsu_ctl.sv
// Directed and randomized checks of c7bexu_lsu_ctl against a behavioural model.
module tb_c7bexu_lsu_ctl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_vld_e = 1'b0, lsu_wr_e = 1'b0, lsu_unsigned_e = 1'b0;
    logic [1:0]  lsu_size_e = 2'd0;
    logic [31:0] lsu_addr_e = '0, lsu_wdata_e = '0;
    logic        ecl_flush = 1'b0;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0, bus_err = 1'b0, bus_ecc = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        lsu_busy, lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3;
    logic        lsu_data_valid_ls3, lsu_wr_fin_ls3;
    logic [31:0] lsu_rdata_ls3;

    int checks = 0;
    int errors = 0;

    c7bexu_lsu_ctl #(.TIMEOUT_CYCLES(T)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .lsu_vld_e             (lsu_vld_e),
        .lsu_wr_e              (lsu_wr_e),
        .lsu_unsigned_e        (lsu_unsigned_e),
        .lsu_size_e            (lsu_size_e),
        .lsu_addr_e            (lsu_addr_e),
        .lsu_wdata_e           (lsu_wdata_e),
        .ecl_flush             (ecl_flush),
        .bus_req               (bus_req),
        .bus_wr                (bus_wr),
        .bus_addr              (bus_addr),
        .bus_be                (bus_be),
        .bus_wdata             (bus_wdata),
        .bus_ack               (bus_ack),
        .bus_err               (bus_err),
        .bus_ecc               (bus_ecc),
        .bus_rdata             (bus_rdata),
        .lsu_busy              (lsu_busy),
        .lsu_except_ale_ls1    (lsu_except_ale_ls1),
        .lsu_except_buserr_ls3 (lsu_except_buserr_ls3),
        .lsu_except_ecc_ls3    (lsu_except_ecc_ls3),
        .lsu_data_valid_ls3    (lsu_data_valid_ls3),
        .lsu_wr_fin_ls3        (lsu_wr_fin_ls3),
        .lsu_rdata_ls3         (lsu_rdata_ls3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int nb = nbytes(size);
        return 4'(((1 << nb) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r = '0;
        int nb = nbytes(size);
        for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rd);
        int nb = nbytes(size);
        logic [31:0] v, mask;
        if (nb == 4) return rd;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = (rd >> (8 * (addr % 4))) & mask;
        if (!uns && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    // Starts and ends at 1 time unit after a rising edge; ack_dly < 0 means no ack.
    task automatic do_op(input logic wr, input logic uns, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_dly,
                         input logic err, input logic ecc, input logic [31:0] rd,
                         input logic fl1, input int fl2, input logic fl3);
        logic mis, acked, killed, to, exp_be, exp_ecc, exp_dv, exp_fin;
        mis = (size == 2'd3) || ((addr % nbytes(size)) != 0);
        lsu_vld_e = 1'b1; lsu_wr_e = wr; lsu_unsigned_e = uns;
        lsu_size_e = size; lsu_addr_e = addr; lsu_wdata_e = wd;
        @(negedge clk);
        chk("idle_busy", 32'(lsu_busy), 32'd0);
        @(posedge clk); #1;
        lsu_vld_e = 1'b0; lsu_wdata_e = $urandom; lsu_addr_e = $urandom;
        ecl_flush = fl1;
        @(negedge clk);
        chk("ls1_busy", 32'(lsu_busy), 32'd1);
        chk("ls1_ale", 32'(lsu_except_ale_ls1), 32'(mis && !fl1));
        chk("ls1_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        ecl_flush = 1'b0;
        if (mis || fl1) begin
            @(negedge clk);
            chk("ale_idle_busy", 32'(lsu_busy), 32'd0);
            chk("ale_idle_req", 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            return;
        end
        acked = 1'b0; killed = 1'b0;
        for (int k = 0; k < T && !acked; k++) begin
            ecl_flush = (k == fl2);
            if (k == fl2) killed = 1'b1;
            if (k == ack_dly) begin
                bus_ack = 1'b1; bus_err = err; bus_ecc = ecc; bus_rdata = rd;
                acked = 1'b1;
            end
            @(negedge clk);
            chk("ls2_req", 32'(bus_req), 32'd1);
            chk("ls2_wr", 32'(bus_wr), 32'(wr));
            chk("ls2_addr", bus_addr, addr & ~32'd3);
            chk("ls2_be", 32'(bus_be), 32'(m_be(size, addr)));
            if (wr) chk("ls2_wdata", bus_wdata, m_wdata(size, wd));
            @(posedge clk); #1;
            ecl_flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_ecc = 1'b0;
            bus_rdata = $urandom;
        end
        to = !acked;
        ecl_flush = fl3;
        exp_be  = !killed && !fl3 && (to || err);
        exp_ecc = !killed && !fl3 && !exp_be && !wr && ecc;
        exp_dv  = !killed && !fl3 && !exp_be && !wr && !ecc;
        exp_fin = !killed && !fl3 && !exp_be && wr;
        @(negedge clk);
        chk("ls3_busy", 32'(lsu_busy), 32'd1);
        chk("ls3_req", 32'(bus_req), 32'd0);
        chk("ls3_buserr", 32'(lsu_except_buserr_ls3), 32'(exp_be));
        chk("ls3_ecc", 32'(lsu_except_ecc_ls3), 32'(exp_ecc));
        chk("ls3_dv", 32'(lsu_data_valid_ls3), 32'(exp_dv));
        chk("ls3_wrfin", 32'(lsu_wr_fin_ls3), 32'(exp_fin));
        if (exp_dv) chk("ls3_rdata", lsu_rdata_ls3, m_load(size, uns, addr, rd));
        @(posedge clk); #1;
        ecl_flush = 1'b0;
        @(negedge clk);
        chk("post_busy", 32'(lsu_busy), 32'd0);
        chk("post_pulse", 32'({lsu_except_buserr_ls3, lsu_except_ecc_ls3,
                               lsu_data_valid_ls3, lsu_wr_fin_ls3}), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(lsu_busy), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_rdata", lsu_rdata_ls3, 32'd0);
        chk("rst_pulses", 32'({lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3,
                               lsu_data_valid_ls3, lsu_wr_fin_ls3}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(0, 0, 2'd2, 32'h1000, 0, 0, 0, 0, 32'hDEADBEEF, 0, -1, 0);
        do_op(0, 0, 2'd0, 32'h1003, 0, 0, 0, 0, 32'h80123456, 0, -1, 0);
        do_op(0, 1, 2'd0, 32'h1003, 0, 0, 0, 0, 32'h80123456, 0, -1, 0);
        do_op(1, 0, 2'd1, 32'h2001, 32'h1234, 0, 0, 0, 0, 0, -1, 0);
        do_op(1, 0, 2'd0, 32'h2002, 32'h000000A5, 4, 0, 0, 0, 0, -1, 0);
        do_op(0, 0, 2'd2, 32'h3000, 0, -1, 0, 0, 0, 0, -1, 0);
        do_op(0, 0, 2'd2, 32'h3004, 0, T - 1, 0, 0, 32'h11223344, 0, -1, 0);
        do_op(0, 0, 2'd1, 32'h3002, 0, 1, 1, 0, 32'h55667788, 0, -1, 0);
        do_op(0, 0, 2'd2, 32'h3008, 0, 0, 0, 1, 32'h99AABBCC, 0, -1, 0);
        do_op(1, 0, 2'd2, 32'h300C, 32'hCAFEF00D, 0, 0, 1, 0, 0, -1, 0);
        do_op(0, 0, 2'd2, 32'h4000, 0, 3, 0, 0, 32'h12345678, 0, 1, 0);
        do_op(0, 0, 2'd2, 32'h4004, 0, 0, 0, 0, 32'h12345678, 1, -1, 0);
        do_op(0, 0, 2'd2, 32'h4008, 0, 0, 0, 0, 32'h12345678, 0, -1, 1);
        do_op(0, 0, 2'd3, 32'h4010, 0, 0, 0, 0, 0, 0, -1, 0);

        // Reset in the middle of LS2 drops the request without waiting for a clock.
        lsu_vld_e = 1'b1; lsu_wr_e = 1'b0; lsu_size_e = 2'd2; lsu_addr_e = 32'h5000;
        @(posedge clk); #1;
        lsu_vld_e = 1'b0;
        @(posedge clk); #3;
        chk("mid_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(bus_req), 32'd0);
        chk("rst_mid_busy", 32'(lsu_busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            int dly, f2;
            dly = $urandom_range(0, T + 1);
            if (dly >= T) dly = -1;
            f2 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_op(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  dly, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), f2, ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
